// File: rtl/cpu_pkg.sv
// Shared LEGv8 pipeline definitions: opcode constants, the architectural NOP,
// and the fetch-stage state encoding.
package cpu_pkg;

    localparam logic [5:0]  OP_B      = 6'b000101;
    localparam logic [7:0]  OP_BCOND  = 8'h54;
    localparam logic [7:0]  OP_CBZ    = 8'hB4;
    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        REDIRECT
    } fstate_t;

endpackage

// File: rtl/branch_target_calc.sv
// Branch-target adder for the instruction held in IF/ID: decodes B / B.cond /
// CBZ, sign-extends the word offset and adds it to the instruction's PC.
module branch_target_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] offset;
    logic              unused_low_bits;

    assign unused_low_bits = ^instr[4:0];

    always_comb begin
        offset = '0;
        if (instr[31:26] == OP_B) begin
            offset = {{(ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
        end else if (instr[31:24] == OP_BCOND || instr[31:24] == OP_CBZ) begin
            offset = {{(ADDR_W-21){instr[23]}}, instr[23:5], 2'b00};
        end
    end

    // Wrap-around past 2^ADDR_W is intentional and silent.
    assign target = pc + offset;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC, IF/ID register and taken-branch counter.
// Define BRANCH_DELAY_SLOT_EN to execute the sequential instruction after a taken branch.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              BrTaken,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] br_target,
    output logic [CNT_W-1:0]  br_count
);

    fstate_t           fstate, fstate_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [31:0]       instr_n;
    logic [ADDR_W-1:0] id_pc_n;
    logic              valid_n;
    logic [CNT_W-1:0]  count_n;
    logic              redirect;

    branch_target_calc #(.ADDR_W(ADDR_W)) u_target (
        .instr  (if_id_instr),
        .pc     (if_id_pc),
        .target (br_target)
    );

    assign imem_addr = pc;

    // A bubble (or the boot slot) never redirects, whatever BrTaken says.
    assign redirect = BrTaken && if_id_valid && (fstate == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fstate      <= BOOT;
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            br_count    <= '0;
        end else begin
            fstate      <= fstate_n;
            pc          <= pc_n;
            if_id_instr <= instr_n;
            if_id_pc    <= id_pc_n;
            if_id_valid <= valid_n;
            br_count    <= count_n;
        end
    end

    always_comb begin
        fstate_n = fstate;
        pc_n     = pc;
        instr_n  = if_id_instr;
        id_pc_n  = if_id_pc;
        valid_n  = if_id_valid;
        count_n  = br_count;

        if (!stall) begin
            if (redirect) begin
                pc_n = br_target;
                if (br_count != '1) begin
                    count_n = br_count + CNT_W'(1);
                end
`ifdef BRANCH_DELAY_SLOT_EN
                instr_n  = imem_rdata;
                id_pc_n  = pc;
                valid_n  = 1'b1;
                fstate_n = RUN;
`else
                instr_n  = NOP_INSTR;
                id_pc_n  = '0;
                valid_n  = 1'b0;
                fstate_n = REDIRECT;
`endif
            end else begin
                // BOOT, REDIRECT and plain RUN all fetch sequentially here.
                pc_n     = pc + ADDR_W'(4);
                instr_n  = imem_rdata;
                id_pc_n  = pc;
                valid_n  = 1'b1;
                fstate_n = RUN;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage (default build, no delay slot),
// plus a small-counter instance for saturation.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    typedef struct {
        logic        stall;
        logic        br;
        logic [63:0] exp_pc;
        logic [63:0] exp_id_pc;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [63:0] exp_target;
        logic [15:0] exp_count;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic        if_id_valid;
    logic [63:0] br_target;
    logic [15:0] br_count;

    logic [63:0] ovr_a0, ovr_a1;
    logic [31:0] ovr_w0, ovr_w1;

    logic        s_br;
    logic [63:0] s_imem_addr;
    logic [31:0] s_if_id_instr;
    logic [63:0] s_if_id_pc;
    logic        s_if_id_valid;
    logic [63:0] s_br_target;
    logic [1:0]  s_br_count;

    int nchecks = 0;
    int nerrors = 0;

    vec_t vecs[16];

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .BrTaken     (br_taken),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .br_target   (br_target),
        .br_count    (br_count)
    );

    fetch_stage #(.CNT_W(2)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .stall       (1'b0),
        .BrTaken     (s_br),
        .imem_addr   (s_imem_addr),
        .imem_rdata  (32'h14000001),
        .if_id_instr (s_if_id_instr),
        .if_id_pc    (s_if_id_pc),
        .if_id_valid (s_if_id_valid),
        .br_target   (s_br_target),
        .br_count    (s_br_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: a PC-derived ALU-style pattern with two patchable words.
    always_comb begin
        imem_rdata = 32'hAA000000 | {8'h00, imem_addr[23:0]};
        if (imem_addr == ovr_a0) imem_rdata = ovr_w0;
        else if (imem_addr == ovr_a1) imem_rdata = ovr_w1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nchecks++;
        if (actual !== expected) begin
            nerrors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic b);
        stall    = s;
        br_taken = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [63:0] pc, input logic [63:0] id_pc,
                            input logic valid, input logic [31:0] instr,
                            input logic [63:0] tgt, input logic [15:0] cnt);
        checkOutput({tag, " imem_addr"},   imem_addr,           pc);
        checkOutput({tag, " if_id_pc"},    if_id_pc,            id_pc);
        checkOutput({tag, " if_id_valid"}, 64'(if_id_valid),    64'(valid));
        checkOutput({tag, " if_id_instr"}, 64'(if_id_instr),    64'(instr));
        checkOutput({tag, " br_target"},   br_target,           tgt);
        checkOutput({tag, " br_count"},    64'(br_count),       64'(cnt));
    endtask

    function automatic vec_t mk(input logic s, input logic b, input logic [63:0] pc,
                                input logic [63:0] id_pc, input logic v,
                                input logic [31:0] ins, input logic [63:0] tgt,
                                input logic [15:0] cnt);
        vec_t r;
        r.stall = s;       r.br = b;
        r.exp_pc = pc;     r.exp_id_pc = id_pc;
        r.exp_valid = v;   r.exp_instr = ins;
        r.exp_target = tgt; r.exp_count = cnt;
        return r;
    endfunction

    initial begin
        // B +3 words at 0x8, CBZ -1 word at 0x20.
        ovr_a0 = 64'h8;  ovr_w0 = 32'h14000003;
        ovr_a1 = 64'h20; ovr_w1 = 32'hB4FFFFE0;

        vecs[0]  = mk(0, 0, 64'h04, 64'h00, 1, 32'hAA000000, 64'h00, 0);
        vecs[1]  = mk(0, 0, 64'h08, 64'h04, 1, 32'hAA000004, 64'h04, 0);
        vecs[2]  = mk(0, 0, 64'h0C, 64'h08, 1, 32'h14000003, 64'h14, 0);
        vecs[3]  = mk(0, 1, 64'h14, 64'h00, 0, NOP,          64'h00, 1);
        vecs[4]  = mk(0, 1, 64'h18, 64'h14, 1, 32'hAA000014, 64'h14, 1);
        vecs[5]  = mk(0, 0, 64'h1C, 64'h18, 1, 32'hAA000018, 64'h18, 1);
        vecs[6]  = mk(0, 0, 64'h20, 64'h1C, 1, 32'hAA00001C, 64'h1C, 1);
        vecs[7]  = mk(0, 0, 64'h24, 64'h20, 1, 32'hB4FFFFE0, 64'h1C, 1);
        vecs[8]  = mk(1, 1, 64'h24, 64'h20, 1, 32'hB4FFFFE0, 64'h1C, 1);
        vecs[9]  = mk(1, 1, 64'h24, 64'h20, 1, 32'hB4FFFFE0, 64'h1C, 1);
        vecs[10] = mk(0, 1, 64'h1C, 64'h00, 0, NOP,          64'h00, 2);
        vecs[11] = mk(0, 0, 64'h20, 64'h1C, 1, 32'hAA00001C, 64'h1C, 2);
        vecs[12] = mk(0, 0, 64'h24, 64'h20, 1, 32'hB4FFFFE0, 64'h1C, 2);
        vecs[13] = mk(0, 1, 64'h1C, 64'h00, 0, NOP,          64'h00, 3);
        vecs[14] = mk(1, 1, 64'h1C, 64'h00, 0, NOP,          64'h00, 3);
        vecs[15] = mk(0, 0, 64'h20, 64'h1C, 1, 32'hAA00001C, 64'h1C, 3);

        reset    = 1'b1;
        stall    = 1'b0;
        br_taken = 1'b0;
        s_br     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 64'h0, 64'h0, 0, NOP, 64'h0, 16'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].br);
            checkAll($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_id_pc,
                     vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_target,
                     vecs[i].exp_count);
        end

        // Enter REDIRECT, then reset between edges: must clear without a clock edge.
        applyStimulus(0, 0);
        checkAll("pre_redir", 64'h24, 64'h20, 1, 32'hB4FFFFE0, 64'h1C, 16'd3);
        applyStimulus(0, 1);
        checkAll("redir", 64'h1C, 64'h0, 0, NOP, 64'h0, 16'd4);
        br_taken = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        checkAll("async_reset", 64'h0, 64'h0, 0, NOP, 64'h0, 16'h0);
        ovr_a0 = 64'h0;
        ovr_w0 = 32'h17FFFFFF;
        #2;
        reset = 1'b0;

        // B -1 word at PC 0: target wraps to the top of the address space.
        applyStimulus(0, 0);
        checkAll("wrap_fetch", 64'h4, 64'h0, 1, 32'h17FFFFFF, 64'hFFFF_FFFF_FFFF_FFFC, 16'h0);
        applyStimulus(0, 1);
        checkAll("wrap_redir", 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, NOP, 64'h0, 16'h1);
        applyStimulus(0, 0);
        checkAll("wrap_pc", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'hAAFFFFFC,
                 64'hFFFF_FFFF_FFFF_FFFC, 16'h1);

        // Saturation on a 2-bit counter: branch +4 repeatedly, one redirect every two edges.
        reset = 1'b1;
        #4;
        s_br  = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("sat edge1 imem_addr", s_imem_addr, 64'h4);
        checkOutput("sat edge1 br_target", s_br_target, 64'h4);
        checkOutput("sat edge1 valid", 64'(s_if_id_valid), 64'h1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sat edge4 count", 64'(s_br_count), 64'h2);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("sat edge12 count", 64'(s_br_count), 64'h3);
        checkOutput("sat edge12 valid", 64'(s_if_id_valid), 64'h0);
        checkOutput("sat edge12 instr", 64'(s_if_id_instr), 64'(NOP));
        checkOutput("sat edge12 if_id_pc", s_if_id_pc, 64'h0);
        s_br = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
